conv1_window_gen: RTL and testbench

Streaming 3x3 window generator that feeds the conv1 calculation stage. It accepts a raster-order pixel stream of 32-bit words, one pixel per accepted beat. It buffers the two previous image rows and emits every fully-populated 3x3 neighbourhood (valid convolution, no padding) as nine words plus a valid strobe. It sits directly upstream of the conv1 filter bank and drives that block's `data_out[0:8]` / `valid_in` inputs.

---
 rtl/conv1_window_gen.sv | 79 +++++++
 tb/tb_conv1_window_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift array.
// Emits every fully populated neighbourhood of a raster pixel stream.
module conv1_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] pixel_in,
  input  logic          valid_in,
  output logic [DW-1:0] data_out [0:8],
  output logic          valid_out,
  output logic          frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // valid_in/pixel_in form a beat on every rising edge with valid_in=1;
  // there is no ready, and valid_out is a one-cycle strobe with no stall.
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] lb0 [0:IMG_W-1];
  logic [DW-1:0] lb1 [0:IMG_W-1];
  logic [DW-1:0] win [0:8];
  logic [DW-1:0] top_new;
  logic [DW-1:0] mid_new;
  logic          col_last;
  logic          row_last;
  logic          in_window;

  assign top_new   = lb1[col];
  assign mid_new   = lb0[col];
  assign col_last  = (col == CW'(IMG_W - 1));
  assign row_last  = (row == RW'(IMG_H - 1));
  assign in_window = (row >= RW'(2)) && (col >= CW'(2));

  // Line buffers carry no reset; the row/col gate keeps stale data hidden.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      valid_out  <= valid_in && in_window;
      frame_done <= valid_in && row_last && col_last;
      if (valid_in) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= top_new;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= mid_new;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= pixel_in;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  assign data_out = win;

endmodule

// File: tb/tb_conv1_window_gen.sv
// Bench for conv1_window_gen: three sizes (5x4, 28x28, 3x3) driven from one
// stimulus path and checked against a frame-image reference model.
module tb_conv1_window_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pixel;
  logic        valid;
  int          sel;

  logic        a_vi, b_vi, c_vi;
  logic [31:0] a_d [0:8];
  logic [31:0] b_d [0:8];
  logic [31:0] c_d [0:8];
  logic        a_v, b_v, c_v, a_fd, b_fd, c_fd;
  logic [31:0] m_d [0:8];
  logic        m_v, m_fd;

  int total = 0;
  int bad   = 0;
  int win_cnt, fd_cnt;
  int cnt [3];
  logic [31:0] lp [3];
  logic [31:0] img [0:27][0:27];

  always #5 clk = ~clk;

  assign a_vi = valid && (sel == 0);
  assign b_vi = valid && (sel == 1);
  assign c_vi = valid && (sel == 2);

  conv1_window_gen #(.IMG_W(5),  .IMG_H(4),  .DW(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel), .valid_in(a_vi),
    .data_out(a_d), .valid_out(a_v), .frame_done(a_fd));
  conv1_window_gen #(.IMG_W(28), .IMG_H(28), .DW(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel), .valid_in(b_vi),
    .data_out(b_d), .valid_out(b_v), .frame_done(b_fd));
  conv1_window_gen #(.IMG_W(3),  .IMG_H(3),  .DW(32)) dut_c (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel), .valid_in(c_vi),
    .data_out(c_d), .valid_out(c_v), .frame_done(c_fd));

  always_comb begin
    m_v  = a_v;
    m_fd = a_fd;
    m_d  = a_d;
    if (sel == 1) begin
      m_v = b_v; m_fd = b_fd; m_d = b_d;
    end else if (sel == 2) begin
      m_v = c_v; m_fd = c_fd; m_d = c_d;
    end
  end

  function automatic int img_w();
    return (sel == 0) ? 5 : (sel == 1) ? 28 : 3;
  endfunction

  function automatic int img_h();
    return (sel == 0) ? 4 : (sel == 1) ? 28 : 3;
  endfunction

  function automatic logic [287:0] out_word();
    logic [287:0] p = '0;
    for (int i = 0; i < 9; i++) p = {p[255:0], m_d[i]};
    return p;
  endfunction

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle without touching the model.
  task automatic step(input logic [31:0] pix, input bit v);
    pixel = pix;
    valid = v;
    @(posedge clk);
    #1;
    valid = 1'b0;
    if (v) lp[sel] = pix;
    if (m_v) win_cnt++;
    if (m_fd) fd_cnt++;
  endtask

  // Drive one cycle and compare against the image model.
  task automatic send(input logic [31:0] pix, input bit v);
    int r, c, w, h;
    bit ev, efd;
    logic [287:0] ew;
    w = img_w();
    h = img_h();
    r = cnt[sel] / w;
    c = cnt[sel] % w;
    ev = 0; efd = 0; ew = '0;
    if (v) begin
      img[r][c] = pix;
      ev  = (r >= 2) && (c >= 2);
      efd = (cnt[sel] == w * h - 1);
      if (ev)
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            ew = {ew[255:0], img[r - 2 + dr][c - 2 + dc]};
      cnt[sel] = (cnt[sel] + 1) % (w * h);
    end
    step(pix, v);
    chk("valid_out", {287'd0, m_v}, {287'd0, ev});
    chk("frame_done", {287'd0, m_fd}, {287'd0, efd});
    chk("hold_d8", {256'd0, m_d[8]}, {256'd0, lp[sel]});
    if (ev) chk("window", out_word(), ew);
  endtask

  task automatic clear_counts();
    win_cnt = 0;
    fd_cnt  = 0;
  endtask

  typedef struct {
    logic [31:0] pix;
    logic        v;
    logic        fd;
    logic [31:0] d0;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t act=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl = '{
      '{0, 0, 0, 0},  '{1, 0, 0, 0},  '{2, 0, 0, 0},  '{3, 0, 0, 0},  '{4, 0, 0, 0},
      '{5, 0, 0, 0},  '{6, 0, 0, 0},  '{7, 0, 0, 0},  '{8, 0, 0, 0},  '{9, 0, 0, 0},
      '{10, 0, 0, 0}, '{11, 0, 0, 0}, '{12, 1, 0, 0}, '{13, 1, 0, 1}, '{14, 1, 0, 2},
      '{15, 0, 0, 0}, '{16, 0, 0, 0}, '{17, 1, 0, 5}, '{18, 1, 0, 6}, '{19, 1, 1, 7}
    };
    sel = 0; rst_n = 1'b0; valid = 1'b0; pixel = '0;
    for (int k = 0; k < 3; k++) begin cnt[k] = 0; lp[k] = '0; end
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {287'd0, m_v}, 288'd0);
    chk("rst_fd", {287'd0, m_fd}, 288'd0);
    chk("rst_data", out_word(), 288'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 5x4 continuous frame from the vector table
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].pix, 1'b1);
      chk("tbl_valid", {287'd0, m_v}, {287'd0, tbl[i].v});
      chk("tbl_fd", {287'd0, m_fd}, {287'd0, tbl[i].fd});
      chk("tbl_d8", {256'd0, m_d[8]}, {256'd0, tbl[i].pix});
      if (tbl[i].v) chk("tbl_d0", {256'd0, m_d[0]}, {256'd0, tbl[i].d0});
      if (i == 12)
        chk("tbl_first", out_word(), {32'd0, 32'd1, 32'd2, 32'd5, 32'd6, 32'd7, 32'd10, 32'd11, 32'd12});
      if (i == 19)
        chk("tbl_last", out_word(), {32'd7, 32'd8, 32'd9, 32'd12, 32'd13, 32'd14, 32'd17, 32'd18, 32'd19});
    end
    chk("tbl_count", 288'(win_cnt), 288'd6);

    // 5x4 with random gaps between beats
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 5)) send(32'hdead_beef, 1'b0);
      send(32'(i), 1'b1);
    end
    chk("gap_count", 288'(win_cnt), 288'd6);
    chk("gap_fd", 288'(fd_cnt), 288'd1);

    // two back-to-back frames, second offset by 100
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      send((i < 20) ? 32'(i) : 32'(i + 80), 1'b1);
      if (i == 32)
        chk("b2b_first2", out_word(), {32'd100, 32'd101, 32'd102, 32'd105, 32'd106, 32'd107, 32'd110, 32'd111, 32'd112});
    end
    chk("b2b_count", 288'(win_cnt), 288'd12);
    chk("b2b_fd", 288'(fd_cnt), 288'd2);

    // reset after pixel 8, then restart the frame
    for (int i = 0; i <= 8; i++) send(32'(i), 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {287'd0, m_v}, 288'd0);
    chk("mrst_fd", {287'd0, m_fd}, 288'd0);
    chk("mrst_data", out_word(), 288'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin cnt[k] = 0; lp[k] = '0; end
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      send(32'(i), 1'b1);
      if (i == 11) chk("mrst_none_early", 288'(win_cnt), 288'd0);
      if (i == 12)
        chk("mrst_first", out_word(), {32'd0, 32'd1, 32'd2, 32'd5, 32'd6, 32'd7, 32'd10, 32'd11, 32'd12});
    end

    // 28x28 indexed frame, then a random-valued frame with gaps
    sel = 1;
    clear_counts();
    for (int i = 0; i < 784; i++) send(32'(i), 1'b1);
    chk("big_count", 288'(win_cnt), 288'd676);
    chk("big_fd", 288'(fd_cnt), 288'd1);
    clear_counts();
    for (int i = 0; i < 784; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) send($urandom, 1'b0);
      send($urandom, 1'b1);
    end
    chk("rnd_count", 288'(win_cnt), 288'd676);

    // minimum 3x3 frame
    sel = 2;
    clear_counts();
    for (int i = 1; i <= 9; i++) begin
      send(32'(i), 1'b1);
      if (i == 9) begin
        chk("min_window", out_word(), {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9});
        chk("min_both", {286'd0, m_v, m_fd}, 288'd3);
      end
    end
    chk("min_count", 288'(win_cnt), 288'd1);
    send(32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
